// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory request/response plus the execution-stage
// presentation and redirect signals. master = fetch_sequencer, slave = memory/execute side.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ex_ready;
  logic        pc_v_x;
  logic [31:0] pc_x;
  logic [31:0] pc_i;
  logic        inst_v_i;
  logic [31:0] inst_i;

  modport master (
    output imem_req, imem_addr, pc_i, inst_v_i, inst_i,
    input  imem_gnt, imem_rvalid, imem_rdata, ex_ready, pc_v_x, pc_x
  );

  modport slave (
    input  imem_req, imem_addr, pc_i, inst_v_i, inst_i,
    output imem_gnt, imem_rvalid, imem_rdata, ex_ready, pc_v_x, pc_x
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Purpose: sequential instruction fetch with in-order response buffering and branch redirect.
// Latency: instruction presented 2 cycles after its grant at the earliest (no bypass).
// Backpressure: ex_ready holds the FIFO head; fetch stalls once in-flight + buffered reach BUF_DEPTH.

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Push and pop on a full FIFO is legal: the head is read before the slot is rewritten.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !clear && count == (AW+1)'(DEPTH)));
  assert property (@(posedge clk) disable iff (reset)
    !(pop && !clear && count == '0));
endmodule

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);
  localparam int            CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  state_t       state, state_nxt;
  logic [31:0]  fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] remaining;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] pcq_count;
  logic         credit;
  logic         req;
  logic         issue;
  logic         dat_push;
  logic         dat_pop;
  logic         dat_empty;
  logic [31:0]  pcq_head;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // Reads still owed by memory once this cycle's response (if any) is accounted for.
  assign remaining = outstanding - CW'(bus.imem_rvalid);
  assign credit    = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
  assign issue     = req && bus.imem_gnt;

  always_comb begin
    discard_nxt = discard;
    if (bus.pc_v_x)
      discard_nxt = remaining;
    else if (bus.imem_rvalid && discard != '0)
      discard_nxt = discard - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      BOOT:  state_nxt = RUN;
      RUN: begin
        req = !bus.pc_v_x && credit;
        if (bus.pc_v_x && remaining != '0) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!bus.pc_v_x && discard_nxt == '0) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding + CW'(issue) - CW'(bus.imem_rvalid);
      discard     <= discard_nxt;
      if (bus.pc_v_x)
        fetch_pc <= bus.pc_x;
      else if (issue)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  assign dat_push   = bus.imem_rvalid && discard == '0 && !bus.pc_v_x;
  assign dat_empty  = fifo_count == '0;
  assign dat_pop    = bus.inst_v_i && bus.ex_ready;
  assign push_entry = '{pc: pcq_head, inst: bus.imem_rdata};

  // Issued addresses, popped in step with accepted responses so each datum gets its PC.
  fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.pc_v_x),
    .push     (issue),
    .push_dat (fetch_pc),
    .pop      (dat_push),
    .head_dat (pcq_head),
    .count    (pcq_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_data_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.pc_v_x),
    .push     (dat_push),
    .push_dat (push_entry),
    .pop      (dat_pop),
    .head_dat (head_entry),
    .count    (fifo_count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.inst_v_i  = !dat_empty && !bus.pc_v_x;
  assign bus.pc_i      = head_entry.pc;
  assign bus.inst_i    = head_entry.inst;

  assert property (@(posedge clk) disable iff (reset)
    !(bus.imem_rvalid && outstanding == '0));
  assert property (@(posedge clk) disable iff (reset)
    !(issue && outstanding == CW'(BUF_DEPTH)));
  assert property (@(posedge clk) disable iff (reset)
    discard <= outstanding);
  assert property (@(posedge clk) disable iff (reset)
    !(dat_push && pcq_count == '0));
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: in-order memory model with configurable latency,
// presented-stream scoreboard, redirect/flush, grant stall, PC wrap and async reset.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();
  fetch_sequencer_if bus2 ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_checks = 0;
  int          n_errors = 0;
  ent_t        got[$];
  mreq_t       mq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: record grant/presentation before the edge, then drive memory responses after it.
  task automatic tick();
    logic        g;
    logic [31:0] ga;
    #1;
    g  = bus.imem_req & bus.imem_gnt;
    ga = bus.imem_addr;
    if (bus.inst_v_i && bus.ex_ready) got.push_back(ent_t'({bus.pc_i, bus.inst_i}));
    @(posedge clk);
    #1;
    cyc++;
    if (bus.imem_rvalid && mq.size() > 0) mq.delete(0);
    if (g) mq.push_back('{ga, cyc - 1 + mem_lat});
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mq[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  endtask

  task automatic expect_stream(input int min_n);
    ent_t e;
    if (min_n > 0) chk("stream_len", (got.size() >= min_n) ? 32'd1 : 32'd0, 32'd1);
    while (got.size() != 0) begin
      e = got.pop_front();
      chk("stream_pc", e.pc, exp_pc);
      chk("stream_inst", e.inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic drain();
    bus.imem_gnt = 1'b0;
    bus.ex_ready = 1'b1;
    repeat (4) tick();
    expect_stream(0);
  endtask

  always @(negedge clk) begin
    if (!reset && dut.dat_push)
      chk("push_when_full", (dut.fifo_count == 2'd2 && !dut.dat_pop) ? 32'd1 : 32'd0, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    bus.imem_gnt = 1'b0;  bus.imem_rvalid = 1'b0;  bus.imem_rdata = '0;
    bus.ex_ready = 1'b0;  bus.pc_v_x = 1'b0;       bus.pc_x = '0;
    bus2.imem_gnt = 1'b1; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
    bus2.ex_ready = 1'b0; bus2.pc_v_x = 1'b0;      bus2.pc_x = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_inst_v", bus.inst_v_i, 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFFC);

    // Test 1: straight-line fetch, gnt=1, 1-cycle latency
    bus.imem_gnt = 1'b1;
    bus.ex_ready = 1'b1;
    exp_pc = 32'h0;
    reset = 1'b0;
    #1;
    chk("boot_req", bus.imem_req, 0);
    tick();
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    chk("wrap_req", bus2.imem_req, 1);
    chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", bus2.imem_addr, 32'h0000_0000);
    repeat (8) tick();
    expect_stream(3);

    // Test 2: execution stall fills the buffer and stops requests
    bus.ex_ready = 1'b0;
    repeat (5) tick();
    expect_stream(0);
    chk("stall_req", bus.imem_req, 0);
    chk("stall_vld", bus.inst_v_i, 1);
    chk("stall_pc", bus.pc_i, exp_pc);
    chk("stall_inst", bus.inst_i, mem_word(exp_pc));
    bus.ex_ready = 1'b1;
    repeat (8) tick();
    expect_stream(4);

    // Test 3: redirect with two reads in flight
    drain();
    mem_lat = 3;
    bus.imem_gnt = 1'b1;
    tick();
    tick();
    chk("inflight_req_off", bus.imem_req, 0);
    bus.pc_v_x = 1'b1;
    bus.pc_x = 32'h100;
    #1;
    chk("redir_squash", bus.inst_v_i, 0);
    chk("redir_req", bus.imem_req, 0);
    tick();
    bus.pc_v_x = 1'b0;
    exp_pc = 32'h100;
    mem_lat = 1;
    #1;
    chk("flush_req", bus.imem_req, 0);
    w = 0;
    while (!bus.imem_req && w < 8) begin
      tick();
      w++;
    end
    chk("flush_exit", (w < 8) ? 32'd1 : 32'd0, 32'd1);
    chk("redir_addr", bus.imem_addr, 32'h100);
    repeat (10) tick();
    expect_stream(2);

    // Test 4: redirect coincides with the last in-flight response, FIFO non-empty
    drain();
    bus.ex_ready = 1'b0;
    bus.imem_gnt = 1'b1;
    tick();
    tick();
    chk("pre_squash_vld", bus.inst_v_i, 1);
    bus.pc_v_x = 1'b1;
    bus.pc_x = 32'h200;
    #1;
    chk("squash_vld", bus.inst_v_i, 0);
    tick();
    bus.pc_v_x = 1'b0;
    exp_pc = 32'h200;
    #1;
    chk("norun_flush_req", bus.imem_req, 1);
    chk("norun_flush_addr", bus.imem_addr, 32'h200);
    bus.ex_ready = 1'b1;
    repeat (8) tick();
    expect_stream(2);

    // Test 5: grant withheld for 3 cycles
    drain();
    bus.pc_v_x = 1'b1;
    bus.pc_x = 32'h8;
    tick();
    bus.pc_v_x = 1'b0;
    exp_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nognt_req", bus.imem_req, 1);
      chk("nognt_addr", bus.imem_addr, 32'h8);
      tick();
    end
    bus.imem_gnt = 1'b1;
    tick();
    chk("post_gnt_addr", bus.imem_addr, 32'hC);
    repeat (8) tick();
    expect_stream(3);

    // Test 6: asynchronous reset while flushing
    drain();
    mem_lat = 3;
    bus.imem_gnt = 1'b1;
    tick();
    tick();
    bus.pc_v_x = 1'b1;
    bus.pc_x = 32'h300;
    tick();
    bus.pc_v_x = 1'b0;
    #1;
    chk("flush_addr", bus.imem_addr, 32'h300);
    #2;
    reset = 1'b1;
    mq.delete();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_req", bus.imem_req, 0);
    chk("arst_vld", bus.inst_v_i, 0);
    chk("arst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    mem_lat = 1;
    exp_pc = 32'h0;
    got.delete();
    bus.ex_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("reboot_req", bus.imem_req, 0);
    tick();
    chk("reboot_addr", bus.imem_addr, 32'h0);
    repeat (6) tick();
    expect_stream(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
